serial_tx_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer that shares one 32-bit serial transmitter (PISO) among NUM_REQ requesters.

---
 rtl/serial_tx_arb_pkg.sv | 11 +
 rtl/serial_tx_arbiter_rr_picker.sv | 37 +++
 rtl/serial_tx_arbiter.sv | 123 ++++++++++++
 tb/tb_serial_tx_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_arb_pkg.sv
// serial_tx_arb_pkg: shared FSM state type and index-width helper for serial_tx_arbiter
package serial_tx_arb_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_GAP} arb_state_t;

    // Width of an index/counter able to hold 0..n-1, never narrower than 1 bit
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_tx_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick of the first set request at or after ptr
//  req    in   NUM_REQ  request vector
//  ptr    in   IW       round-robin start index
//  found  out  1        any request set
//  winner out  IW       index of the picked request (valid with found)
module rr_picker
    import serial_tx_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]          req,
    input  logic [idx_w(NUM_REQ)-1:0]   ptr,
    output logic                        found,
    output logic [idx_w(NUM_REQ)-1:0]   winner
);

    localparam int IW = idx_w(NUM_REQ);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [IW-1:0]        off;
    logic [IW:0]          sum;

    // Rotate so ptr lands on bit 0, priority-encode the lowest set bit,
    // then add ptr back modulo NUM_REQ to recover the real index.
    always_comb begin
        dbl = {req, req};
        rot = dbl[ptr +: NUM_REQ];
        found = |rot;
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (rot[i]) off = IW'(i);
        sum = {1'b0, ptr} + {1'b0, off};
        winner = (sum >= (IW+1)'(NUM_REQ)) ? IW'(sum - (IW+1)'(NUM_REQ)) : IW'(sum);
    end

endmodule

// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: round-robin arbiter sequencing one shared serial transmitter
//  Clk, Reset            clock, synchronous active-high reset
//  ReqValid/ReqData      requester words (word i at [i*SIZE +: SIZE])
//  ReqReady              one-hot accept pulse, word captured this cycle
//  TxDataIn/TxSample/TxStartTx/TxDone/TxBusy   transmitter interface
//  GrantId, Active       current owner, busy from LOAD through GAP
//  DoneValid, DoneId     completion pulse and owner
//  Error                 SEND timeout pulse
// Optional feature: define SERIAL_TX_ARB_TIMEOUT_EN to bound SEND to TIMEOUT_CYCLES.
module serial_tx_arbiter
    import serial_tx_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int SIZE           = 32,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic [NUM_REQ-1:0]            ReqValid,
    input  logic [NUM_REQ*SIZE-1:0]       ReqData,
    output logic [NUM_REQ-1:0]            ReqReady,
    output logic [SIZE-1:0]               TxDataIn,
    output logic                          TxSample,
    output logic                          TxStartTx,
    input  logic                          TxDone,
    input  logic                          TxBusy,
    output logic [idx_w(NUM_REQ)-1:0]     GrantId,
    output logic                          Active,
    output logic                          DoneValid,
    output logic [idx_w(NUM_REQ)-1:0]     DoneId,
    output logic                          Error
);

    localparam int IW = idx_w(NUM_REQ);
    localparam int GW = idx_w(GAP_CYCLES);

    arb_state_t    state, state_next;
    logic [IW-1:0] ptr, winner;
    logic          found, timeout;
    logic [GW-1:0] gap_cnt;
    logic          unused_busy;

    assign unused_busy = TxBusy;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
        .req    (ReqValid),
        .ptr    (ptr),
        .found  (found),
        .winner (winner)
    );

`ifdef SERIAL_TX_ARB_TIMEOUT_EN
    localparam int TW = idx_w(TIMEOUT_CYCLES);
    logic [TW-1:0] to_cnt;
    // Counts SEND cycles from 0; the last allowed cycle is TIMEOUT_CYCLES-1
    always_ff @(posedge Clk) begin
        if (Reset || state != ST_SEND)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 1'b1;
    end
    assign timeout = (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign Error   = (state == ST_SEND) && timeout && !TxDone;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
    assign Error   = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // ReqReady is gated by Reset so a held reset never accepts a word
    always_comb begin
        state_next = state;
        ReqReady   = '0;
        case (state)
            ST_IDLE: if (found && !Reset) begin
                state_next = ST_LOAD;
                ReqReady   = NUM_REQ'(1) << winner;
            end
            ST_LOAD: state_next = ST_SEND;
            ST_SEND: if (TxDone || timeout) state_next = ST_GAP;
            ST_GAP:  if (gap_cnt == '0) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign TxSample  = (state == ST_LOAD);
    assign TxStartTx = (state == ST_SEND);
    assign Active    = (state != ST_IDLE);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr       <= '0;
            GrantId   <= '0;
            TxDataIn  <= '0;
            gap_cnt   <= '0;
            DoneValid <= 1'b0;
            DoneId    <= '0;
        end else begin
            DoneValid <= (state == ST_SEND) && TxDone;
            if (state == ST_SEND && TxDone)
                DoneId <= GrantId;
            if (state == ST_IDLE && found) begin
                TxDataIn <= ReqData[int'(winner)*SIZE +: SIZE];
                GrantId  <= winner;
                ptr      <= (winner == IW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            end
            // Preloaded throughout SEND so GAP starts at GAP_CYCLES-1 and ends at 0
            if (state == ST_SEND)
                gap_cnt <= GW'(GAP_CYCLES - 1);
            else if (gap_cnt != '0)
                gap_cnt <= gap_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb_serial_tx_arbiter: directed self-checking bench for serial_tx_arbiter
module tb_serial_tx_arbiter;

`ifdef SERIAL_TX_ARB_TIMEOUT_EN
    localparam int TO = 64;
`else
    localparam int TO = 4096;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic [31:0]  tx_data;
    logic         tx_sample, tx_start, tx_done = 1'b0, tx_busy = 1'b0;
    logic [1:0]   grant_id, done_id;
    logic         active, done_valid, error;

    int errors = 0;
    int checks = 0;
    int inv_viol = 0;
    int done_cnt = 0;

    logic [31:0] d [4] = '{32'h1111_0000, 32'h2222_0001, 32'hA5A5_0F0F, 32'h4444_0003};

    assign req_data = {d[3], d[2], d[1], d[0]};

    serial_tx_arbiter #(.NUM_REQ(4), .SIZE(32), .GAP_CYCLES(2), .TIMEOUT_CYCLES(TO)) dut (
        .Clk(clk), .Reset(rst), .ReqValid(req_valid), .ReqData(req_data), .ReqReady(req_ready),
        .TxDataIn(tx_data), .TxSample(tx_sample), .TxStartTx(tx_start), .TxDone(tx_done),
        .TxBusy(tx_busy), .GrantId(grant_id), .Active(active), .DoneValid(done_valid),
        .DoneId(done_id), .Error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_sample && tx_start) inv_viol++;
        if ($countones(req_ready) > 1) inv_viol++;
        if (done_valid) done_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Called in the LOAD cycle; runs k idle SEND cycles, a TxDone cycle and the gap,
    // returning at the start of the following IDLE cycle.
    task automatic complete(input int k);
        cyc();
        repeat (k) cyc();
        tx_done = 1'b1;
        cyc();
        tx_done = 1'b0;
        repeat (2) cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'hF;
        cyc();
        cyc();
        #1;
        checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        checks++; if ({tx_sample, tx_start, active, done_valid, error} !== 5'b0) begin errors++; $display("FAIL reset_strobes: got %b want 00000", {tx_sample, tx_start, active, done_valid, error}); end
        checks++; if ({tx_data, grant_id, done_id} !== 36'h0) begin errors++; $display("FAIL reset_regs: got %h want 0", {tx_data, grant_id, done_id}); end
        req_valid = 4'h0;
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_single();
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b want 0100", req_ready); end
        cyc();
        req_valid = 4'b0;
        #1;
        checks++; if ({tx_sample, tx_start} !== 2'b10) begin errors++; $display("FAIL single_load: got %b want 10", {tx_sample, tx_start}); end
        checks++; if (tx_data !== 32'hA5A5_0F0F) begin errors++; $display("FAIL single_data: got %h want a5a50f0f", tx_data); end
        checks++; if (grant_id !== 2'd2 || active !== 1'b1 || req_ready !== 4'b0) begin errors++; $display("FAIL single_grant: got id=%0d act=%b rdy=%b want 2 1 0000", grant_id, active, req_ready); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (i == 2) tx_done = 1'b1;
            #1;
            checks++; if ({tx_sample, tx_start, done_valid} !== 3'b010) begin errors++; $display("FAIL single_send%0d: got %b want 010", i, {tx_sample, tx_start, done_valid}); end
        end
        cyc();
        tx_done = 1'b0;
        #1;
        checks++; if ({done_valid, done_id, tx_start, active} !== 5'b1_10_0_1) begin errors++; $display("FAIL single_done: got %b want 11001", {done_valid, done_id, tx_start, active}); end
        cyc();
        #1;
        checks++; if ({done_valid, active, tx_data} !== {2'b01, 32'hA5A5_0F0F}) begin errors++; $display("FAIL single_gap: got %b %b %h want 0 1 a5a50f0f", done_valid, active, tx_data); end
        cyc();
        #1;
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL single_idle: got %b want 0", active); end
    endtask

    task automatic test_round_robin();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        req_valid = 4'hF;
        for (int g = 0; g < 5; g++) begin
            logic [3:0] exp_rdy;
            logic [1:0] exp_id;
            exp_id = 2'(g % 4);
            exp_rdy = 4'b0001 << exp_id;
            #1;
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready%0d: got %b want %b", g, req_ready, exp_rdy); end
            cyc();
            if (g == 4) req_valid = 4'h0;
            #1;
            checks++; if (tx_data !== d[exp_id] || grant_id !== exp_id || req_ready !== 4'b0) begin errors++; $display("FAIL rr_load%0d: got %h id=%0d rdy=%b want %h id=%0d 0000", g, tx_data, grant_id, req_ready, d[exp_id], exp_id); end
            cyc();
            tx_done = 1'b1;
            cyc();
            tx_done = 1'b0;
            #1;
            checks++; if (done_valid !== 1'b1 || done_id !== exp_id) begin errors++; $display("FAIL rr_done%0d: got v=%b id=%0d want 1 %0d", g, done_valid, done_id, exp_id); end
            cyc();
            #1;
            checks++; if (req_ready !== 4'b0 || active !== 1'b1) begin errors++; $display("FAIL rr_gap%0d: got rdy=%b act=%b want 0000 1", g, req_ready, active); end
            cyc();
        end
    endtask

    task automatic test_fairness();
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL fair_first: got %b want 0010", req_ready); end
        cyc();
        req_valid = 4'b1010;
        complete(1);
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL fair_second: got %b want 1000", req_ready); end
        cyc();
        req_valid = 4'b0010;
        complete(0);
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL fair_third: got %b want 0010", req_ready); end
        cyc();
        req_valid = 4'b0;
        complete(0);
    endtask

    task automatic test_reset_mid();
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rstmid_grant: got %b want 0100", req_ready); end
        cyc();
        req_valid = 4'b1001;
        cyc();
        cyc();
        rst = 1'b1;
        #1;
        checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL rstmid_send: got %b want 1", tx_start); end
        cyc();
        #1;
        checks++; if ({req_ready, tx_sample, tx_start, active, done_valid, error} !== 9'b0) begin errors++; $display("FAIL rstmid_zero: got %b want 000000000", {req_ready, tx_sample, tx_start, active, done_valid, error}); end
        checks++; if ({tx_data, grant_id} !== 34'h0) begin errors++; $display("FAIL rstmid_regs: got %h want 0", {tx_data, grant_id}); end
        cyc();
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rstmid_ptr: got %b want 0001", req_ready); end
        cyc();
        req_valid = 4'b0;
        #1;
        checks++; if (grant_id !== 2'd0 || tx_data !== d[0] || done_valid !== 1'b0) begin errors++; $display("FAIL rstmid_load: got id=%0d %h v=%b want 0 %h 0", grant_id, tx_data, done_valid, d[0]); end
        complete(0);
    endtask

    task automatic test_spurious();
        tx_done = 1'b1;
        repeat (3) cyc();
        #1;
        checks++; if (active !== 1'b0 || done_valid !== 1'b0) begin errors++; $display("FAIL spur_idle: got act=%b v=%b want 0 0", active, done_valid); end
        tx_done = 1'b0;
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL spur_grant: got %b want 0010", req_ready); end
        cyc();
        req_valid = 4'b0;
        cyc();
        tx_done = 1'b1;
        cyc();
        #1;
        checks++; if (done_valid !== 1'b1 || done_id !== 2'd1) begin errors++; $display("FAIL spur_done: got v=%b id=%0d want 1 1", done_valid, done_id); end
        cyc();
        #1;
        checks++; if (done_valid !== 1'b0 || active !== 1'b1) begin errors++; $display("FAIL spur_gap: got v=%b act=%b want 0 1", done_valid, active); end
        cyc();
        tx_done = 1'b0;
        #1;
        checks++; if (done_valid !== 1'b0 || active !== 1'b0) begin errors++; $display("FAIL spur_end: got v=%b act=%b want 0 0", done_valid, active); end
        checks++; if (inv_viol !== 0) begin errors++; $display("FAIL invariants: got %0d violations want 0", inv_viol); end
        checks++; if (done_cnt !== 11) begin errors++; $display("FAIL done_count: got %0d want 11", done_cnt); end
    endtask

`ifdef SERIAL_TX_ARB_TIMEOUT_EN
    task automatic test_timeout();
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL to_grant: got %b want 0001", req_ready); end
        cyc();
        req_valid = 4'b0;
        cyc();
        for (int i = 1; i < 64; i++) begin
            #1;
            checks++; if (error !== 1'b0 || tx_start !== 1'b1) begin errors++; $display("FAIL to_send%0d: got err=%b st=%b want 0 1", i, error, tx_start); end
            cyc();
        end
        #1;
        checks++; if (error !== 1'b1 || tx_start !== 1'b1) begin errors++; $display("FAIL to_pulse: got err=%b st=%b want 1 1", error, tx_start); end
        cyc();
        #1;
        checks++; if (error !== 1'b0 || tx_start !== 1'b0 || done_valid !== 1'b0 || active !== 1'b1) begin errors++; $display("FAIL to_gap: got err=%b st=%b v=%b act=%b want 0 0 0 1", error, tx_start, done_valid, active); end
        repeat (2) cyc();
        #1;
        checks++; if (active !== 1'b0 || done_cnt !== 11) begin errors++; $display("FAIL to_idle: got act=%b dones=%0d want 0 11", active, done_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_reset_mid();
        test_spurious();
`ifdef SERIAL_TX_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
